// File: rtl/dsi_pkg.sv
// Shared types and helpers for the DSI lane scheduler: state encoding, lane count,
// byte-count decode and lane masks.
package dsi_pkg;

    localparam int LANES         = 4;
    localparam int GUARD_DEFAULT = 8;
    localparam int UCNT_DEFAULT  = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        STREAM     = 2'd1,
        WAIT_START = 2'd2,
        WAIT_END   = 2'd3
    } sched_state_t;

    // s_bytes encoding: 0 means a full word.
    function automatic logic [2:0] decode_nb(input logic [1:0] bytes);
        return (bytes == 2'b00) ? 3'd4 : {1'b0, bytes};
    endfunction

    // Bit i set when lane i lies at or above the valid byte count.
    function automatic logic [LANES-1:0] lanes_at_or_above(input logic [2:0] nb);
        logic [LANES-1:0] m;
        for (int i = 0; i < LANES; i++) begin
            m[i] = (i >= int'(nb));
        end
        return m;
    endfunction

endpackage

// File: rtl/dsi_sched_eof_mask.sv
// Per-lane write/eof/dummy masks for the word held in the scheduler's holding register.
module dsi_sched_eof_mask
    import dsi_pkg::*;
(
    input  logic [2:0]       nb,
    input  logic             first_word,
    input  logic             h_last,
    output logic [LANES-1:0] write_mask,
    output logic [LANES-1:0] eof_mask,
    output logic [LANES-1:0] dummy_mask
);

    always_comb begin
        write_mask = '1;
        eof_mask   = '0;
        dummy_mask = '0;
        if (h_last) begin
            for (int i = 0; i < LANES; i++) begin
                if (i < int'(nb)) begin
                    eof_mask[i] = 1'b1;
                end else if (first_word) begin
                    // Single-word frame: unused lanes still need a frame, so send a dummy.
                    eof_mask[i]   = 1'b1;
                    dummy_mask[i] = 1'b1;
                end else begin
                    // This lane already got its eof on the previous word.
                    write_mask[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/dsi_lane_scheduler.sv
// Splits a 32-bit packet stream across four DSI lanes with one word of lookahead.
// Optional underrun counter: define DSI_SCHED_UNDERRUN_CNT_EN.
//
// state      | meaning
// IDLE       | ready for the first word of a frame
// STREAM     | holding register loaded; issue when all lanes ready and lookahead known
// WAIT_START | last word issued; wait for any lane to go active, or guard timeout
// WAIT_END   | wait for every lane to return to LP stop
module dsi_lane_scheduler
    import dsi_pkg::*;
#(
    parameter int GUARD_CYCLES = GUARD_DEFAULT
`ifdef DSI_SCHED_UNDERRUN_CNT_EN
    ,
    parameter int UCNT_W = UCNT_DEFAULT
`endif
) (
    input  logic              clk_base,
    input  logic              reset_n,
    input  logic [31:0]       s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_last,
    input  logic [1:0]        s_bytes,
    input  logic              s_hs,
    output logic [31:0]       lane_data,
    output logic [LANES-1:0]  lane_write,
    output logic [LANES-1:0]  lane_eof,
    output logic [LANES-1:0]  lane_dummy,
    output logic              lane_type,
    input  logic [LANES-1:0]  lane_ready,
    input  logic [LANES-1:0]  lane_active,
    output logic              busy
`ifdef DSI_SCHED_UNDERRUN_CNT_EN
    ,
    output logic [UCNT_W-1:0] underrun_cnt
`endif
);

    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

    sched_state_t     state, state_nxt;
    logic             run_en;
    logic [31:0]      h_data;
    logic             h_last;
    logic [2:0]       h_nb;
    logic             first_word;
    logic [GW-1:0]    guard_cnt;
    logic             all_rdy;
    logic             take;
    logic [LANES-1:0] m_write, m_eof, m_dummy;

    assign all_rdy = &lane_ready;
    assign take    = s_valid && s_ready;
    assign busy    = (state != IDLE);

    dsi_sched_eof_mask u_eof_mask (
        .nb         (h_nb),
        .first_word (first_word),
        .h_last     (h_last),
        .write_mask (m_write),
        .eof_mask   (m_eof),
        .dummy_mask (m_dummy)
    );

    always_comb begin
        state_nxt  = state;
        s_ready    = 1'b0;
        lane_data  = '0;
        lane_write = '0;
        lane_eof   = '0;
        lane_dummy = '0;
        case (state)
            IDLE: begin
                s_ready = run_en;
                if (run_en && s_valid) state_nxt = STREAM;
            end
            STREAM: begin
                if (all_rdy && h_last) begin
                    lane_data  = h_data;
                    lane_write = m_write;
                    lane_eof   = m_eof;
                    lane_dummy = m_dummy;
                    state_nxt  = WAIT_START;
                end else if (all_rdy && s_valid) begin
                    // Lanes above the lookahead word's byte count end in this word.
                    lane_data  = h_data;
                    lane_write = m_write;
                    lane_eof   = s_last ? lanes_at_or_above(decode_nb(s_bytes)) : '0;
                    s_ready    = 1'b1;
                end
            end
            WAIT_START: begin
                if (|lane_active || guard_cnt == GUARD_LAST) state_nxt = WAIT_END;
            end
            WAIT_END: begin
                if (lane_active == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_base or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            run_en     <= 1'b0;
            h_data     <= '0;
            h_last     <= 1'b0;
            h_nb       <= 3'd4;
            first_word <= 1'b0;
            lane_type  <= 1'b0;
            guard_cnt  <= '0;
        end else begin
            state  <= state_nxt;
            run_en <= 1'b1;
            if (take) begin
                h_data     <= s_data;
                h_last     <= s_last;
                h_nb       <= s_last ? decode_nb(s_bytes) : 3'd4;
                first_word <= (state == IDLE);
                if (state == IDLE) lane_type <= s_hs;
            end
            if (state == WAIT_START && state_nxt == WAIT_START) begin
                guard_cnt <= guard_cnt + 1'b1;
            end else begin
                guard_cnt <= '0;
            end
        end
    end

`ifdef DSI_SCHED_UNDERRUN_CNT_EN
    always_ff @(posedge clk_base or negedge reset_n) begin
        if (!reset_n) begin
            underrun_cnt <= '0;
        end else if (state == STREAM && all_rdy && !h_last && !s_valid
                     && underrun_cnt != '1) begin
            underrun_cnt <= underrun_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: doc/dsi_lane_scheduler.md
Name: dsi_lane_scheduler

Overview:
- Splits a 32-bit packet stream from the DSI packetizer across four dsi_lane byte inputs, one byte per lane per word (byte i goes to lane i).
- Writes all four lanes in the same cycle only, to keep the burst aligned across lanes.
- Generates per-lane end_of_frame and dummy_frame flags and the frame-wide data_type.
- Holds the next frame until every lane has returned to LP stop.

Parameters:
- GUARD_CYCLES, 8: clk_base cycles to wait for any lane_active rise after the final write before the scheduler proceeds anyway.
- UCNT_W, 16: width of the underrun counter (optional feature only).

Ports:
- clk_base  in  1  logic clock, shared with dsi_lane.
- reset_n  in  1  reset; asynchronous, active-low.
- s_data  in  32  packet word; byte i is for lane i.
- s_valid  in  1  s_data valid.
- s_ready  out  1  word accepted when s_valid && s_ready.
- s_last  in  1  last word of the frame.
- s_bytes  in  2  valid bytes in the last word; 0 means 4, 1..3 literal; lanes below the count are valid.
- s_hs  in  1  frame type (1 = HS); sampled on the first word only.
- lane_data  out  32  byte i drives lane i data_input.
- lane_write  out  4  per-lane data_write.
- lane_eof  out  4  per-lane end_of_frame.
- lane_dummy  out  4  per-lane dummy_frame.
- lane_type  out  1  data_type, common to all lanes.
- lane_ready  in  4  per-lane data_ready.
- lane_active  in  4  per-lane active.
- busy  out  1  high whenever state != IDLE.
- underrun_cnt  out  UCNT_W  optional feature only.

Behaviour:
- Reset values: s_ready, busy, lane_write, lane_eof, lane_dummy and lane_type are 0; lane_data is 0; state is IDLE; holding register H is empty.
- IDLE: s_ready is 1.
  - On accepting a word, load it into H, latch s_hs into lane_type, set first_word=1 and go to STREAM.
  - If that word has s_last set, also set h_last and h_nb = decode(s_bytes).
- STREAM: H is issued only with one word of lookahead, so that end-of-frame flags for earlier lanes can be placed correctly.
  - all_rdy = &lane_ready.
  - Issue condition: all_rdy && (h_last || s_valid).
  - Otherwise lane_write = 0 and H holds.
- Case 1, issue with H not last and s_valid: lane_write = 4'hF.
  - If s_last, lane_eof[i] = (i >= decode(s_bytes)), because those lanes end in H.
  - If not s_last, lane_eof = 0.
  - The s_data word is accepted in the same cycle (s_ready = 1) and H <= s_data. first_word is cleared.
- Case 2, issue with H last, for each lane i:
  - i < h_nb: write with eof = 1.
  - i >= h_nb and first_word: write with dummy = 1 and eof = 1.
  - i >= h_nb and not first_word: no write, since the lane already ended.
  - s_ready = 0. Next state is WAIT_START.
- s_ready = 0 in STREAM unless issuing Case 1.
  - No skid: an s_valid word is never accepted without H issuing in the same cycle.
- lane_data = H bytes on issue cycles, 0 otherwise.
- Outputs are combinational from H, state and lane_ready. The lanes register them on the same clk_base edge, giving 0-cycle latency from issue to lane capture.
- WAIT_START:
  - Go to WAIT_END when |lane_active, or when the guard counter reaches GUARD_CYCLES-1.
  - The guard counter counts 0..GUARD_CYCLES-1 and clears on exit.
- WAIT_END: go to IDLE when lane_active == 0.
- s_hs changes mid-frame are ignored.
- An s_last word in the IDLE acceptance behaves as a single-word frame: Case 2 fires with first_word = 1.
- An async reset at any point returns to the reset state immediately. A partial frame is dropped; no eof is generated.

Optional Feature:
- Macro: DSI_SCHED_UNDERRUN_CNT_EN.
- With the macro: in STREAM, when all_rdy && !h_last && !s_valid (the lanes are starving mid-burst), underrun_cnt increments.
  - It saturates at all-ones and clears only on reset.
- Without the macro: the port is absent and no counter logic is built.

Decomposition:
- Package dsi_pkg holds:
  - the state encoding (IDLE=0, STREAM=1, WAIT_START=2, WAIT_END=3);
  - LANES=4;
  - the nb decode function (2'b00->4);
  - GUARD default.
- One sub-module is natural: dsi_sched_eof_mask. It is combinational and takes nb, first_word and h_last. It produces the write, eof and dummy masks.

Test Plan:
- 3-word frame, s_bytes=0, all lanes ready:
  - writes on 3 cycles;
  - eof=4'hF only on the third write;
  - busy returns to 0 after lane_active falls.
- 2-word frame, last word s_bytes=2:
  - first write has lane_eof=4'b1100;
  - second write has lane_write=4'b0011 and lane_eof=4'b0011.
- Single word, s_last, s_bytes=1:
  - lane_write=4'hF, lane_eof=4'hF, lane_dummy=4'b1110;
  - lane_type equals s_hs.
- lane_ready[2]=0 for 5 cycles mid-frame: no writes and no words accepted during the stall; byte order is intact on resume.
- lane_active never asserts: the scheduler leaves WAIT_START after exactly 8 cycles and returns to IDLE.
- s_valid low for 4 cycles mid-frame with the macro defined and all lanes ready: underrun_cnt=4; an async reset mid-frame clears all outputs to 0.
